// File: rtl/act_stream_packer.sv
// act_stream_packer: assembles CIN serial channel samples into one AXI-Stream pixel word,
// tagging row ends (tlast) and frame start (tuser) over an IMG_WIDTH x IMG_HEIGHT frame.
module act_stream_packer #(
   parameter int DATA_W     = 8,
   parameter int CIN        = 32,
   parameter int IMG_WIDTH  = 224,
   parameter int IMG_HEIGHT = 224
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [DATA_W-1:0]       s_ch_data,
   input  logic                    s_ch_valid,
   output logic                    s_ch_ready,
   output logic [CIN*DATA_W-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tuser,
   output logic                    busy,
   output logic                    o_intr
);

   localparam int WORD_W = CIN * DATA_W;
   localparam int CH_W   = (CIN > 1) ? $clog2(CIN) : 1;
   localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CIN - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q,     state_d;
   logic [CH_W-1:0]     ch_cnt_q,    ch_cnt_d;
   logic [WORD_W-1:0]   pack_q,      pack_d;
   logic                pack_full_q, pack_full_d;
   logic [WORD_W-1:0]   out_data_q,  out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q,  out_last_d;
   logic                out_user_q,  out_user_d;
   logic [COL_W-1:0]    col_q,       col_d;
   logic [ROW_W-1:0]    row_q,       row_d;
   logic                busy_q,      busy_d;
   logic                intr_q,      intr_d;

   logic                slot_free;
   logic                pix_last;
   logic                ready_s;
   logic                accept;
   logic                word_done;
   logic                load_out;
   logic [WORD_W-1:0]   merged;

   // Handshake qualifiers and the pack word with the incoming sample merged in
   always_comb begin
      slot_free = !out_valid_q || m_axis_tready;
      // col/row always index the next word to load, i.e. the one being packed or held
      pix_last  = (col_q == COL_LAST) && (row_q == ROW_LAST);
      if (state_q == ST_RUN) begin
         if (pack_full_q) begin
            ready_s = slot_free && !pix_last;
         end else begin
            ready_s = 1'b1;
         end
      end else begin
         ready_s = 1'b0;
      end
      accept    = ready_s && s_ch_valid;
      word_done = accept && (ch_cnt_q == CH_LAST);
      load_out  = slot_free && (pack_full_q || word_done);
      merged    = pack_q;
      for (int k = 0; k < CIN; k++) begin
         if (ch_cnt_q == CH_W'(k)) begin
            merged[k*DATA_W +: DATA_W] = s_ch_data;
         end else begin
            merged[k*DATA_W +: DATA_W] = pack_q[k*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state logic for the frame FSM, pack path and output register
   always_comb begin
      state_d     = state_q;
      ch_cnt_d    = ch_cnt_q;
      pack_d      = pack_q;
      pack_full_d = pack_full_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_user_d  = out_user_q;
      col_d       = col_q;
      row_d       = row_q;
      busy_d      = busy_q;
      intr_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept) begin
               pack_d = merged;
               if (word_done) begin
                  ch_cnt_d = '0;
               end else begin
                  ch_cnt_d = ch_cnt_q + 1'b1;
               end
            end else begin
               pack_d = pack_q;
            end
            // A held word leaving while a new one completes keeps the pack register full
            if (pack_full_q) begin
               pack_full_d = !slot_free || word_done;
            end else begin
               pack_full_d = word_done && !slot_free;
            end
            if (load_out) begin
               if (pack_full_q) begin
                  out_data_d = pack_q;
               end else begin
                  out_data_d = merged;
               end
               out_valid_d = 1'b1;
               out_last_d  = (col_q == COL_LAST);
               out_user_d  = (col_q == '0) && (row_q == '0);
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d = '0;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (pix_last) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (out_valid_q && m_axis_tready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               out_user_d  = 1'b0;
            end else begin
               out_valid_d = out_valid_q;
            end
         end
         ST_DRAIN: begin
            if (out_valid_q && m_axis_tready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               out_user_d  = 1'b0;
               state_d     = ST_IDLE;
               busy_d      = 1'b0;
               intr_d      = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            pack_full_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         ch_cnt_q    <= '0;
         pack_q      <= '0;
         pack_full_q <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_user_q  <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         busy_q      <= 1'b0;
         intr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_cnt_q    <= ch_cnt_d;
         pack_q      <= pack_d;
         pack_full_q <= pack_full_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_user_q  <= out_user_d;
         col_q       <= col_d;
         row_q       <= row_d;
         busy_q      <= busy_d;
         intr_q      <= intr_d;
      end
   end

   assign s_ch_ready    = ready_s;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tuser  = out_user_q;
   assign busy          = busy_q;
   assign o_intr        = intr_q;

endmodule

// File: tb/tb_act_stream_packer.sv
// Scoreboard bench for act_stream_packer (CIN=4, DATA_W=8, 3x2 frame): stimulus pushes
// expected words, a negedge monitor pops and compares on every output handshake.
module tb_act_stream_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  s_ch_data;
   logic        s_ch_valid;
   logic        s_ch_ready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        busy;
   logic        o_intr;

   act_stream_packer #(
      .DATA_W(8), .CIN(4), .IMG_WIDTH(3), .IMG_HEIGHT(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .s_ch_data(s_ch_data), .s_ch_valid(s_ch_valid), .s_ch_ready(s_ch_ready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .busy(busy), .o_intr(o_intr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        user;
      logic        eof;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   intr_seen = 0;

   logic [31:0] fb [6] = '{32'h43424140, 32'h47464544, 32'h4B4A4948,
                           32'h4F4E4D4C, 32'h53525150, 32'h57565554};
   logic [31:0] fc [6] = '{32'h63626160, 32'h67666564, 32'h6B6A6968,
                           32'h6F6E6D6C, 32'h73727170, 32'h77767574};
   logic [31:0] fd [6] = '{32'hA4A3A2A1, 32'hB3B2B1B0, 32'hB7B6B5B4,
                           32'hBBBAB9B8, 32'hBFBEBDBC, 32'hC3C2C1C0};

   // Monitor: output handshakes against the scoreboard, stall stability, o_intr timing
   initial begin
      exp_t        e;
      logic        stall_prev = 1'b0;
      logic        expect_intr = 1'b0;
      logic [34:0] held = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (expect_intr) begin
               checks++;
               if (!(o_intr && !busy && !m_axis_tvalid)) begin
                  errors++;
                  $display("FAIL intr_pulse: o_intr=%0b busy=%0b tvalid=%0b, want 1 0 0", o_intr, busy, m_axis_tvalid);
               end
               expect_intr = 1'b0;
            end else if (o_intr) begin
               checks++;
               errors++;
               $display("FAIL intr_spurious: o_intr=1, want 0");
            end
            if (o_intr) intr_seen++;
            if (stall_prev) begin
               checks++;
               if ({m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tvalid} !== held) begin
                  errors++;
                  $display("FAIL stall_stable: got %h, want %h", {m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tvalid}, held);
               end
            end
            if (m_axis_tvalid && m_axis_tready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL word_unexpected: got %h, want no word", m_axis_tdata);
               end else begin
                  e = sb.pop_front();
                  if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tuser !== e.user) begin
                     errors++;
                     $display("FAIL word: got data=%h last=%0b user=%0b, want data=%h last=%0b user=%0b",
                              m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
                  end
                  if (e.eof) expect_intr = 1'b1;
               end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held = {m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tvalid};
         end else begin
            stall_prev  = 1'b0;
            expect_intr = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic send(input logic [7:0] d);
      int   n;
      logic acc;
      n = 0;
      acc = 1'b0;
      s_ch_data  = d;
      s_ch_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = s_ch_ready;
         @(posedge clk);
         #1;
         n++;
      end
      s_ch_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_timeout: sample %h not accepted in %0d cycles, want accepted", d, n);
      end
   endtask

   // idx is the pixel position in the 3x2 frame: 0 is tuser, 2 and 5 are row ends, 5 ends the frame
   task automatic send_word(input logic [31:0] w, input int idx);
      exp_t e;
      e.data = w;
      e.user = (idx == 0);
      e.last = (idx == 2) || (idx == 5);
      e.eof  = (idx == 5);
      sb.push_back(e);
      send(w[7:0]);
      send(w[15:8]);
      send(w[23:16]);
      send(w[31:24]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_intr(input logic arm);
      int n;
      n = 0;
      while (!o_intr && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("intr_wait", {63'd0, o_intr}, 64'd1);
      if (arm) pulse_start();
   endtask

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog: run exceeded time limit, want completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      time t0;
      time t1;
      reset = 1'b0;
      start = 1'b0;
      s_ch_data = 8'h00;
      s_ch_valid = 1'b0;
      m_axis_tready = 1'b0;

      // reset held low with random inputs
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         start = 1'($urandom_range(0, 1));
         s_ch_valid = 1'($urandom_range(0, 1));
         s_ch_data = 8'($urandom_range(0, 255));
         m_axis_tready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("reset_outputs", {22'd0, s_ch_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, o_intr, m_axis_tdata}, 64'd0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      s_ch_valid = 1'b0;
      m_axis_tready = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // frame A: first word latency, then backpressure on words 2..4
      pulse_start();
      @(negedge clk);
      check("busy_run", {63'd0, busy}, 64'd1);
      @(posedge clk);
      #1;
      send_word(32'h04030201, 0);
      @(negedge clk);
      check("first_word", {28'd0, m_axis_tvalid, m_axis_tuser, m_axis_tlast, 1'b0, m_axis_tdata},
            {28'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h04030201});
      @(posedge clk);
      #1;
      m_axis_tready = 1'b0;
      fork
         begin
            send_word(32'h14131211, 1);
            send_word(32'h18171615, 2);
            send_word(32'h1C1B1A19, 3);
         end
         begin
            repeat (14) @(posedge clk);
            @(negedge clk);
            check("stall_ready", {63'd0, s_ch_ready}, 64'd0);
            check("stall_word", {31'd0, m_axis_tvalid, m_axis_tdata}, {31'd0, 1'b1, 32'h14131211});
            @(posedge clk);
            #1;
            m_axis_tready = 1'b1;
         end
      join
      send_word(32'h24232221, 4);
      send_word(32'h28272625, 5);
      wait_intr(1'b1);

      // frame B, armed in the o_intr cycle: full-rate streaming
      t0 = $time;
      for (int i = 0; i < 6; i++) send_word(fb[i], i);
      t1 = $time;
      check("no_bubbles", 64'((t1 - t0) / 10), 64'd24);
      wait_intr(1'b0);

      // frame C: start pulse mid-frame is ignored
      @(posedge clk);
      #1;
      pulse_start();
      send_word(fc[0], 0);
      send_word(fc[1], 1);
      pulse_start();
      check("busy_after_start", {63'd0, busy}, 64'd1);
      for (int i = 2; i < 6; i++) send_word(fc[i], i);
      wait_intr(1'b0);

      // frame D: reset mid-word discards the partial word
      @(posedge clk);
      #1;
      pulse_start();
      send(8'h55);
      send(8'h66);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      s_ch_valid = 1'b1;
      s_ch_data = 8'h77;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset_idle", {22'd0, s_ch_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, o_intr, m_axis_tdata}, 64'd0);
         @(posedge clk);
         #1;
      end
      s_ch_valid = 1'b0;
      pulse_start();
      for (int i = 0; i < 6; i++) send_word(fd[i], i);
      wait_intr(1'b0);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      check("intr_count", 64'(intr_seen), 64'd4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/act_stream_packer.md
ACT_STREAM_PACKER -- requirements
Module: act_stream_packer

Interface
REQ-001 Parameter DATA_W, default 8, bit width of one channel sample.
REQ-002 Parameter CIN, default 32, channels packed per pixel word.
REQ-003 Parameter IMG_WIDTH, default 224, pixels per row.
REQ-004 Parameter IMG_HEIGHT, default 224, rows per frame.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset  input  1  synchronous, active-low reset: reset=0 at a rising edge resets the block.
REQ-007 start  input  1  arms one frame when sampled high in IDLE.
REQ-008 s_ch_data  input  DATA_W  one channel sample, channel 0 first.
REQ-009 s_ch_valid  input  1  s_ch_data valid.
REQ-010 s_ch_ready  output  1  block accepts s_ch_data this cycle.
REQ-011 m_axis_tdata  output  CIN*DATA_W  packed pixel word.
REQ-012 m_axis_tvalid  output  1  pixel word valid.
REQ-013 m_axis_tready  input  1  downstream accepts the word.
REQ-014 m_axis_tlast  output  1  word is the last pixel of a row.
REQ-015 m_axis_tuser  output  1  word is pixel (row 0, col 0) of a frame.
REQ-016 busy  output  1  frame in progress.
REQ-017 o_intr  output  1  one-cycle frame-done pulse.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when the last frame pixel loads into the output register; DRAIN->IDLE on handshake of that pixel.
REQ-019 busy SHALL be 1 exactly in RUN and DRAIN; start outside IDLE SHALL be ignored.
REQ-020 s_ch_ready SHALL be 0 in IDLE and DRAIN and while the pack register is full and cannot transfer.
REQ-021 A sample transfers when s_ch_valid and s_ch_ready are both 1; sample k (channel counter k, 0..CIN-1) SHALL land in bits [k*DATA_W +: DATA_W]; channel counter wraps CIN-1 -> 0.
REQ-022 Output slot free = m_axis_tvalid==0, or m_axis_tvalid and m_axis_tready both 1 this cycle.
REQ-023 When the CIN-th sample is accepted in cycle T with slot free, the word SHALL appear on m_axis_tdata with m_axis_tvalid=1 at T+1 (latency 1).
REQ-024 If the slot is not free, the full word SHALL be held in the pack register, s_ch_ready=0, and it SHALL move to the output register on the first cycle the slot is free; no word lost or duplicated.
REQ-025 Continuous input with m_axis_tready=1 SHALL sustain one sample per cycle with no bubbles.
REQ-026 While m_axis_tvalid=1 and m_axis_tready=0, tdata, tlast, tuser SHALL hold stable.
REQ-027 col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters SHALL advance on each word load; col wraps to 0 with row increment; tlast=1 iff loaded word has col=IMG_WIDTH-1; tuser=1 iff row=0 and col=0.
REQ-028 o_intr SHALL be 1 for exactly the cycle after the last-pixel handshake, coincident with busy=0 and state IDLE; counters SHALL be 0 on return to IDLE.
REQ-029 A start in the cycle o_intr is high SHALL arm the next frame.

Reset
REQ-030 On reset=0: state IDLE; all counters, pack register, valid flags cleared; s_ch_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, o_intr = 0; m_axis_tdata = 0.
REQ-031 Reset mid-frame SHALL discard any partial or pending words; no output valid until a new start.

Verification (CIN=4, DATA_W=8, IMG_WIDTH=3, IMG_HEIGHT=2)
REQ-032 Hold reset=0 3 cycles with random inputs -> all outputs 0, s_ch_ready=0.
REQ-033 start, then samples 0x01,0x02,0x03,0x04 back-to-back, tready=1 -> one cycle after 0x04: tdata=0x04030201, tvalid=1, tuser=1, tlast=0.
REQ-034 tready=0, feed 12 samples continuously -> first word held stable, s_ch_ready drops after 8th sample accepted; raise tready -> words 1,2 then remaining output in order, none lost.
REQ-035 Full frame of 24 samples, tready=1 -> 6 words, tlast on words 3 and 6, tuser only on word 1, o_intr single pulse the cycle after word 6 handshake, busy=0 then.
REQ-036 After 2 samples drive reset=0 one cycle, then start and feed 0xA1..0xA4 -> first word 0xA4A3A2A1 with tuser=1.
REQ-037 Pulse start during RUN after word 2 -> ignored; frame continues, tlast still on word 3, exactly one o_intr.
